// File: rtl/ss_fifo.sv
// First-word-fall-through beat buffer between the read and write scatter-gather engines of one DMA channel.
// Optional high-water statistic output `hiwat` is compiled in when SS_FIFO_STAT_EN is defined.
module ss_fifo #(
  parameter int AW     = 4,
  parameter int AF_GAP = 2,
  parameter int AE_GAP = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        clr,
  input  logic        push,
  input  logic [31:0] push_dat,
  input  logic [31:0] push_dat64,
  input  logic        push_last,
  output logic        rd_ready,
  input  logic        pop,
  output logic [31:0] pop_dat,
  output logic [31:0] pop_dat64,
  output logic        wr_ready,
  output logic        empty,
  output logic [AW:0] count,
  output logic [1:0]  err
`ifdef SS_FIFO_STAT_EN
  ,
  output logic [AW:0] hiwat
`endif
);

  localparam int            DEPTH   = 1 << AW;
  localparam logic [AW:0]   DEPTH_W = DEPTH[AW:0];
  localparam logic [AW:0]   AF_W    = AF_GAP[AW:0];
  localparam logic [AW:0]   AE_W    = AE_GAP[AW:0];

  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_eot;
  logic [1:0]    r_err;
  logic          r_rd_ready;
  logic          r_wr_ready;

  logic          w_full;
  logic          w_pop_acc;
  logic          w_push_acc;
  logic [AW:0]   w_count_next;
  logic [AW:0]   w_free_next;
  logic          w_eot_next;
  logic [1:0]    w_err_next;
  logic          w_rd_ready_next;
  logic          w_wr_ready_next;

  // A pop at full frees the slot the simultaneous push lands in; a pop at empty is always rejected.
  assign w_full     = (r_count == DEPTH_W);
  assign w_pop_acc  = pop && (r_count != '0);
  assign w_push_acc = push && (!w_full || w_pop_acc);

  assign w_count_next = r_count + {{AW{1'b0}}, w_push_acc} - {{AW{1'b0}}, w_pop_acc};
  assign w_free_next  = DEPTH_W - w_count_next;
  assign w_err_next   = r_err | {pop && !w_pop_acc, push && !w_push_acc};

  always_comb begin
    w_eot_next = r_eot;
    if (w_push_acc && push_last) begin
      w_eot_next = 1'b1;
    end else if (w_pop_acc && (w_count_next == '0)) begin
      w_eot_next = 1'b0;
    end
  end

  // Holding rd_ready low while eot is set keeps the next transfer out of the tail.
  assign w_rd_ready_next = (w_free_next >= AF_W) && !w_eot_next;
  assign w_wr_ready_next = (w_count_next >= AE_W) || (w_eot_next && (w_count_next != '0));

  always_ff @(posedge wb_clk_i) begin
    if (w_push_acc && !clr) begin
      r_mem[r_wptr] <= {push_dat64, push_dat};
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_eot      <= 1'b0;
      r_err      <= 2'b00;
      r_rd_ready <= 1'b0;
      r_wr_ready <= 1'b0;
    end else if (clr) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_eot      <= 1'b0;
      r_err      <= 2'b00;
      r_rd_ready <= 1'b0;
      r_wr_ready <= 1'b0;
    end else begin
      if (w_push_acc) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop_acc) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count    <= w_count_next;
      r_eot      <= w_eot_next;
      r_err      <= w_err_next;
      r_rd_ready <= w_rd_ready_next;
      r_wr_ready <= w_wr_ready_next;
    end
  end

`ifdef SS_FIFO_STAT_EN
  logic [AW:0] r_hiwat;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_hiwat <= '0;
    end else if (clr) begin
      r_hiwat <= '0;
    end else if (r_count > r_hiwat) begin
      r_hiwat <= r_count;
    end
  end

  assign hiwat = r_hiwat;
`endif

  assign {pop_dat64, pop_dat} = r_mem[r_rptr];
  assign rd_ready = r_rd_ready;
  assign wr_ready = r_wr_ready;
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign err      = r_err;

endmodule
